// File: rtl/decode_pkg.sv
// decode_stream shared types and opcode decode helper.
// Opcode classes, FSM states and op-range boundaries.
package decode_pkg;

    typedef enum logic [1:0] {
        NORMAL     = 2'd0,
        NORMAL_IMM = 2'd1,
        EXT        = 2'd2,
        EXT_IMM    = 2'd3
    } instr_t;

    typedef enum logic [1:0] {
        S_OP   = 2'd0,
        S_EXT  = 2'd1,
        S_IMM  = 2'd2,
        S_EMIT = 2'd3
    } state_t;

    localparam logic [3:0] OP_NIMM_LO    = 4'h8;
    localparam logic [3:0] OP_EXT_LO     = 4'hC;
    localparam logic [3:0] OP_EXT_IMM_LO = 4'hE;

    function automatic instr_t op_type(input logic [3:0] op);
        instr_t t;
        t = NORMAL;
        unique case (1'b1)
            (op < OP_NIMM_LO):
                t = NORMAL;
            (op >= OP_NIMM_LO && op < OP_EXT_LO):
                t = NORMAL_IMM;
            (op >= OP_EXT_LO && op < OP_EXT_IMM_LO):
                t = EXT;
            (op >= OP_EXT_IMM_LO):
                t = EXT_IMM;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/decode_stream_type_lut.sv
// Opcode nibble to instruction class lookup.
// Pure combinational table used on the opcode byte.
module decode_type_lut
    import decode_pkg::*;
(
    input  logic [3:0] op,
    output instr_t     typ
);

    // Classify the low opcode nibble
    always_comb begin
        typ = op_type(op);
    end

endmodule

// File: rtl/decode_stream.sv
// Byte-stream instruction assembler and decode stage.
// Builds opcode/ext/immediate bundles, emits one per instruction.
module decode_stream
    import decode_pkg::*;
#(
    parameter int IMM_BYTES = 1,
    parameter int DATA_W    = 8 * IMM_BYTES,
    parameter int REG_AW    = 2
) (
    input  logic              clk,
    input  logic              sync_rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        opc_out,
    output logic              is_ext,
    output logic              has_imm,
    output logic [REG_AW-1:0] dst,
    output logic [DATA_W-1:0] data_out_A,
    output logic [DATA_W-1:0] data_out_B,
    output logic [REG_AW-1:0] regfile_read_A,
    output logic [REG_AW-1:0] regfile_read_B,
    output logic              read_en_A,
    output logic              read_en_B,
    input  logic [DATA_W-1:0] data_A,
    input  logic [DATA_W-1:0] data_B
);

    localparam int CNT_W = (IMM_BYTES > 1) ? $clog2(IMM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(IMM_BYTES - 1);

    state_t              state_q;
    state_t              state_d;
    state_t              op_next;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    instr_t              typ_in;
    instr_t              typ_q;
    logic [7:0]          opc_q;
    logic [REG_AW-1:0]   ra_q;
    logic [REG_AW-1:0]   rb_q;
    logic [DATA_W-1:0]   imm_q;
    logic                accept;
    logic                take_op;

    decode_type_lut u_lut (
        .op  (in_byte[3:0]),
        .typ (typ_in)
    );

    assign in_ready = ~sync_rst & ~flush &
                      ((state_q != S_EMIT) | out_ready);
    assign accept   = in_valid & in_ready;
    assign take_op  = accept &
                      ((state_q == S_OP) | (state_q == S_EMIT));

    // Next state and immediate counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_next = S_EMIT;
        unique case (typ_in)
            NORMAL:     op_next = S_EMIT;
            NORMAL_IMM: op_next = S_IMM;
            EXT:        op_next = S_EXT;
            EXT_IMM:    op_next = S_EXT;
        endcase
        if (flush) begin
            state_d = S_OP;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_OP: begin
                    if (accept) state_d = op_next;
                end
                S_EXT: begin
                    if (accept)
                        state_d = (typ_q == EXT_IMM) ? S_IMM : S_EMIT;
                end
                S_IMM: begin
                    if (accept) begin
                        if (cnt_q == LAST) begin
                            state_d = S_EMIT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (out_ready)
                        state_d = accept ? op_next : S_OP;
                end
            endcase
        end
    end

    // State and counter register
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q <= S_OP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture opcode fields, ext byte and immediate bytes
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            typ_q <= NORMAL;
            opc_q <= '0;
            ra_q  <= '0;
            rb_q  <= '0;
            imm_q <= '0;
        end else begin
            if (take_op) begin
                typ_q <= typ_in;
                opc_q <= {4'b0, in_byte[3:0]};
                ra_q  <= in_byte[4 +: REG_AW];
                rb_q  <= in_byte[6 +: REG_AW];
                imm_q <= '0;
            end
            if (accept && state_q == S_EXT)
                opc_q <= in_byte;
            if (accept && state_q == S_IMM) begin
                for (int i = 0; i < IMM_BYTES; i++) begin
                    if (cnt_q == CNT_W'(i))
                        imm_q[8*i +: 8] <= in_byte;
                end
            end
        end
    end

    assign out_valid      = (state_q == S_EMIT);
    assign opc_out        = opc_q;
    assign is_ext         = (typ_q == EXT) | (typ_q == EXT_IMM);
    assign has_imm        = (typ_q == NORMAL_IMM) | (typ_q == EXT_IMM);
    assign dst            = ra_q;
    assign regfile_read_A = ra_q;
    assign regfile_read_B = rb_q;
    assign read_en_A      = out_valid;
    assign read_en_B      = out_valid & ~has_imm;
    assign data_out_A     = out_valid ? data_A : '0;
    assign data_out_B     = out_valid ? (has_imm ? imm_q : data_B) : '0;

endmodule

// File: tb/tb_decode_stream.sv
// Scoreboard bench for decode_stream with IMM_BYTES=2.
// Randomized byte stream checked against an instruction-level model.
module tb_decode_stream;

    localparam int IB = 2;
    localparam int DW = 16;
    localparam int AW = 2;

    typedef struct packed {
        logic [7:0]    opc;
        logic          is_ext;
        logic          has_imm;
        logic [AW-1:0] dst;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic          ren_a;
        logic          ren_b;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } bund_t;

    logic          clk;
    logic          sync_rst;
    logic          flush;
    logic          in_valid;
    logic [7:0]    in_byte;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    opc_out;
    logic          is_ext;
    logic          has_imm;
    logic [AW-1:0] dst;
    logic [DW-1:0] data_out_A;
    logic [DW-1:0] data_out_B;
    logic [AW-1:0] regfile_read_A;
    logic [AW-1:0] regfile_read_B;
    logic          read_en_A;
    logic          read_en_B;
    logic [DW-1:0] data_A;
    logic [DW-1:0] data_B;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    rdy_mode = 2;
    bund_t sbq[$];
    int    xfer_cyc[$];

    decode_stream #(
        .IMM_BYTES (IB),
        .DATA_W    (DW),
        .REG_AW    (AW)
    ) dut (
        .clk            (clk),
        .sync_rst       (sync_rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_byte        (in_byte),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .opc_out        (opc_out),
        .is_ext         (is_ext),
        .has_imm        (has_imm),
        .dst            (dst),
        .data_out_A     (data_out_A),
        .data_out_B     (data_out_B),
        .regfile_read_A (regfile_read_A),
        .regfile_read_B (regfile_read_B),
        .read_en_A      (read_en_A),
        .read_en_B      (read_en_B),
        .data_A         (data_A),
        .data_B         (data_B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file model contents
    function automatic logic [DW-1:0] rfa(input logic [AW-1:0] r);
        return 16'hA100 + 16'(r) * 16'h0011;
    endfunction

    function automatic logic [DW-1:0] rfb(input logic [AW-1:0] r);
        return 16'hB200 + 16'(r) * 16'h0101;
    endfunction

    assign data_A = rfa(regfile_read_A);
    assign data_B = rfb(regfile_read_B);

    // Byte k of an instruction lives in w[8k+7:8k]
    function automatic int ilen(input logic [31:0] w);
        logic [3:0] op;
        logic       ext;
        logic       imm;
        op  = w[3:0];
        ext = (op >= 4'hC);
        imm = (op >= 4'h8 && op <= 4'hB) || (op >= 4'hE);
        return 1 + (ext ? 1 : 0) + (imm ? IB : 0);
    endfunction

    function automatic bund_t model(input logic [31:0] w);
        bund_t         m;
        logic [3:0]    op;
        logic          ext;
        logic          imm;
        int            base;
        logic [DW-1:0] immv;
        op   = w[3:0];
        ext  = (op >= 4'hC);
        imm  = (op >= 4'h8 && op <= 4'hB) || (op >= 4'hE);
        base = ext ? 2 : 1;
        immv = '0;
        for (int k = 0; k < IB; k++)
            immv[8*k +: 8] = w[8*(base+k) +: 8];
        m.opc     = ext ? w[15:8] : {4'h0, op};
        m.is_ext  = ext;
        m.has_imm = imm;
        m.dst     = w[5:4];
        m.ra      = w[5:4];
        m.rb      = w[7:6];
        m.ren_a   = 1'b1;
        m.ren_b   = ~imm;
        m.a       = rfa(w[5:4]);
        m.b       = imm ? immv : rfb(w[7:6]);
        return m;
    endfunction

    // Execute-side ready pattern
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compare presented bundles, pop on handoff
    always @(negedge clk) begin
        bund_t obs;
        if (!sync_rst) begin
            obs = {opc_out, is_ext, has_imm, dst,
                   regfile_read_A, regfile_read_B,
                   read_en_A, read_en_B, data_out_A, data_out_B};
            checks++;
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_bundle got=%h", obs);
                end else begin
                    if (obs !== sbq[0]) begin
                        errors++;
                        $display("FAIL bundle got=%h exp=%h",
                                 obs, sbq[0]);
                    end
                    if (out_ready) begin
                        void'(sbq.pop_front());
                        xfer_cyc.push_back(cyc);
                    end
                end
            end else if ({data_out_A, data_out_B,
                          read_en_A, read_en_B} !== '0) begin
                errors++;
                $display("FAIL idle_outputs got A=%h B=%h ra=%b rb=%b exp 0",
                         data_out_A, data_out_B, read_en_A, read_en_B);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout byte=%h in_ready=%b exp 1",
                     b, in_ready);
        end
    endtask

    task automatic send_instr(input logic [31:0] w, input bit gaps);
        int n;
        n = ilen(w);
        for (int k = 0; k < n; k++) begin
            if (gaps && $urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 2)) @(posedge clk);
            if (gaps) #1;
            send_byte(w[8*k +: 8]);
        end
        sbq.push_back(model(w));
    endtask

    task automatic wait_empty(input string tag);
        for (int t = 0; t < 500 && sbq.size() != 0; t++)
            @(posedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL %s drain pending=%0d exp 0", tag, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic check_eq(input string tag,
                            input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        @(negedge clk);
        checks++;
        if ({out_valid, opc_out, is_ext, has_imm, dst,
             data_out_A, data_out_B, regfile_read_A,
             regfile_read_B, read_en_A, read_en_B} !== '0) begin
            errors++;
            $display("FAIL %s outputs v=%b opc=%h ext=%b imm=%b dst=%h A=%h B=%h exp all 0",
                     tag, out_valid, opc_out, is_ext, has_imm, dst,
                     data_out_A, data_out_B);
        end
    endtask

    initial begin
        int n;
        sync_rst = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        sync_rst = 1'b0;
        check_reset("reset");

        // Single NORMAL, latency of one cycle
        rdy_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        send_instr(32'h0000_0042, 1'b0);
        @(negedge clk);
        check_eq("latency_valid", 32'(out_valid), 32'd1);
        wait_empty("normal");

        // NORMAL_IMM and EXT_IMM
        send_instr(32'h0000_5A68, 1'b0);
        wait_empty("normal_imm");
        send_instr(32'h1234_910E, 1'b0);
        wait_empty("ext_imm");

        // Back-pressure then back-to-back NORMAL stream
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send_instr(32'h0000_0015, 1'b0);
        in_valid = 1'b1;
        in_byte  = 8'hC6;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("stall_in_ready", 32'(in_ready), 32'd0);
            check_eq("stall_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        rdy_mode = 1;
        send_instr(32'h0000_00C6, 1'b0);
        send_instr(32'h0000_0041, 1'b0);
        send_instr(32'h0000_0092, 1'b0);
        send_instr(32'h0000_00E3, 1'b0);
        send_instr(32'h0000_0037, 1'b0);
        wait_empty("stream");
        n = xfer_cyc.size();
        check_eq("stream_consecutive",
                 32'(xfer_cyc[n-1] - xfer_cyc[n-4]), 32'd3);

        // Flush mid EXT_IMM with a coincident byte
        send_byte(8'h0E);
        send_byte(8'h91);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'h77;
        @(negedge clk);
        check_eq("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("flush_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        send_instr(32'h0000_0003, 1'b0);
        wait_empty("after_flush");

        // Reset mid immediate with gapped input
        send_byte(8'h68);
        send_byte(8'h5A);
        repeat (2) @(posedge clk);
        #1;
        sync_rst = 1'b1;
        @(posedge clk);
        #1;
        sync_rst = 1'b0;
        check_reset("mid_reset");
        @(posedge clk);
        #1;
        send_instr(32'h0000_0001, 1'b0);
        wait_empty("after_reset");

        // Randomized stream with random back-pressure and gaps
        rdy_mode = 0;
        for (int i = 0; i < 300; i++)
            send_instr($urandom(), 1'b1);
        rdy_mode = 1;
        wait_empty("random");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
